// File: rtl/me_pkg.sv
// Shared constants and types for the motion-estimation search engine.
package me_pkg;

  localparam int N         = 46;
  localparam int M         = 16;
  localparam int RANGE     = (N - M) / 2;
  localparam int CW        = 6;
  localparam int SAE_W     = 32;
  localparam int NUM_CANDS = (2 * RANGE + 1) * (2 * RANGE + 1);
  localparam int CNT_W     = $clog2(NUM_CANDS + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  typedef struct packed {
    logic signed [CW-1:0] dx;
    logic signed [CW-1:0] dy;
  } mv_t;

endpackage

// File: rtl/mv_raster_counter.sv
// Raster-order candidate vector generator over the +/-RANGE window; dx runs fastest.
module mv_raster_counter
  import me_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  input  logic advance,
  output mv_t  mv,
  output logic isLast
);

  localparam logic signed [CW-1:0] MV_MAX = CW'(RANGE);
  localparam logic signed [CW-1:0] MV_MIN = -MV_MAX;
  localparam logic signed [CW-1:0] MV_ONE = CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv <= '0;
    end else if (init) begin
      mv.dx <= MV_MIN;
      mv.dy <= MV_MIN;
    end else if (advance) begin
      if (mv.dx == MV_MAX) begin
        mv.dx <= MV_MIN;
        mv.dy <= mv.dy + MV_ONE;
      end else begin
        mv.dx <= mv.dx + MV_ONE;
      end
    end
  end

  assign isLast = (mv.dx == MV_MAX) && (mv.dy == MV_MAX);

endmodule

// File: rtl/me_search_scheduler.sv
// Sweeps every candidate vector through the shared SAE datapath and keeps the minimum.
//   state     | meaning
//   ST_IDLE   | waiting for start; best_* hold the last completed sweep
//   ST_ISSUE  | candidate offered on cand_valid until cand_ready
//   ST_WAIT   | one result outstanding, waiting for sae_valid
//   ST_FINISH | sweep complete, done pulse
module me_search_scheduler
  import me_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    cand_valid,
  input  logic                    cand_ready,
  output logic signed [CW-1:0]    cand_dx,
  output logic signed [CW-1:0]    cand_dy,
  input  logic                    sae_valid,
  input  logic [SAE_W-1:0]        sae,
  output logic signed [CW-1:0]    best_dx,
  output logic signed [CW-1:0]    best_dy,
  output logic [SAE_W-1:0]        best_sae,
  output logic [CNT_W-1:0]        cand_count
);

  state_t           state, stateNext;
  mv_t              candMv, minMv;
  logic [SAE_W-1:0] minSae;
  logic             haveMin;
  logic             isLast, init, advance, resultTake, better;

  assign init       = (state == ST_IDLE) && start;
  assign resultTake = (state == ST_WAIT) && sae_valid && !abort;
  assign advance    = resultTake && !isLast;
  assign better     = !haveMin || (sae < minSae);

  mv_raster_counter uRaster (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (init),
    .advance(advance),
    .mv     (candMv),
    .isLast (isLast)
  );

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:   if (start) stateNext = ST_ISSUE;
      ST_ISSUE:  if (cand_ready) stateNext = ST_WAIT;
      ST_WAIT:   if (sae_valid) stateNext = isLast ? ST_FINISH : ST_ISSUE;
      ST_FINISH: stateNext = ST_IDLE;
      default:   stateNext = ST_IDLE;
    endcase
    if (abort && (state != ST_IDLE)) stateNext = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cand_count <= '0;
      minSae     <= '0;
      minMv      <= '0;
      haveMin    <= 1'b0;
    end else begin
      state <= stateNext;
      if (init) begin
        cand_count <= '0;
        haveMin    <= 1'b0;
      end else if (resultTake) begin
        cand_count <= cand_count + CNT_W'(1);
        if (better) begin
          minSae  <= sae;
          minMv   <= candMv;
          haveMin <= 1'b1;
        end
      end
    end
  end

  // Published on the final result edge so best_* are already valid in the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_sae <= '0;
      best_dx  <= '0;
      best_dy  <= '0;
    end else if (resultTake && isLast) begin
      best_sae <= better ? sae       : minSae;
      best_dx  <= better ? candMv.dx : minMv.dx;
      best_dy  <= better ? candMv.dy : minMv.dy;
    end
  end

  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_FINISH);
  assign cand_valid = (state == ST_ISSUE);
  assign cand_dx    = candMv.dx;
  assign cand_dy    = candMv.dy;

endmodule

// File: tb/tb_me_search_scheduler.sv
// Self-checking bench: randomized SAE datapath model against a raster-sweep reference.
module tb_me_search_scheduler;
  import me_pkg::*;

  localparam int W  = 2 * RANGE + 1;
  localparam int NC = NUM_CANDS;

  logic                 clk = 1'b0;
  logic                 rst_n, start, abort, cand_ready, sae_valid;
  logic [SAE_W-1:0]     sae;
  logic                 busy, done, cand_valid;
  logic signed [CW-1:0] cand_dx, cand_dy, best_dx, best_dy;
  logic [SAE_W-1:0]     best_sae;
  logic [CNT_W-1:0]     cand_count;

  int nChecks = 0;
  int nFails  = 0;
  int unsigned rndSae [NC];

  me_search_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .cand_valid(cand_valid), .cand_ready(cand_ready),
    .cand_dx(cand_dx), .cand_dy(cand_dy), .sae_valid(sae_valid), .sae(sae),
    .best_dx(best_dx), .best_dy(best_dy), .best_sae(best_sae), .cand_count(cand_count)
  );

  always #5 clk = ~clk;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [SAE_W-1:0] sae_for(input int mode, input int dx, input int dy, input int idx);
    if (mode == 0) return SAE_W'(10 * (iabs(dx - 3) + iabs(dy + 5)));
    if (mode == 1) return '1;
    if (idx >= 0 && idx < NC) return rndSae[idx];
    return '0;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < NC; i++) rndSae[i] = 1000 + $urandom_range(0, 63);
  endtask

  // Reference: walk the window in raster order, keep the first strict minimum.
  task automatic model_sweep(input int mode, output int bDx, output int bDy, output logic [SAE_W-1:0] bSae);
    int idx;
    bit have;
    logic [SAE_W-1:0] v;
    idx = 0; have = 0; bDx = 0; bDy = 0; bSae = '0;
    for (int dy = -RANGE; dy <= RANGE; dy++) begin
      for (int dx = -RANGE; dx <= RANGE; dx++) begin
        v = sae_for(mode, dx, dy, idx);
        if (!have || v < bSae) begin
          have = 1; bSae = v; bDx = dx; bDy = dy;
        end
        idx++;
      end
    end
  endtask

  // Datapath stand-in: starts a sweep and services candidates until done, abort or budget.
  task automatic drive_sweep(input int mode, input int readyPct, input int maxDelay, input int holdIdx,
                             input int noiseIdx, input int abortAt, input bit abortWithSae,
                             output int nRes, output int orderErr, output int stabErr,
                             output int doneCyc, output bit aborted, output bit timedOut);
    bit outstanding, offered, noiseDone;
    int holdLeft, waitLeft, curDx, curDy, prevDx, prevDy;
    nRes = 0; orderErr = 0; stabErr = 0; doneCyc = -1; aborted = 0; timedOut = 1;
    outstanding = 0; offered = 0; noiseDone = 0; holdLeft = 3; waitLeft = 0;
    curDx = 0; curDy = 0; prevDx = 0; prevDy = 0;
    start = 1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 20000; cyc++) begin
      cand_ready = 0; sae_valid = 0; sae = $urandom; start = 0;
      if (done) begin
        doneCyc = cyc; timedOut = 0;
        break;
      end
      if (outstanding) begin
        if (waitLeft > 0) waitLeft--;
        else begin
          sae_valid = 1;
          sae = sae_for(mode, curDx, curDy, nRes);
          if (abortWithSae && nRes == abortAt) begin
            abort = 1; aborted = 1; timedOut = 0;
            break;
          end
          nRes++; outstanding = 0;
        end
      end else if (cand_valid) begin
        if (offered && (int'(cand_dx) != prevDx || int'(cand_dy) != prevDy)) stabErr++;
        if (!offered && (int'(cand_dx) != -RANGE + nRes % W || int'(cand_dy) != -RANGE + nRes / W))
          orderErr++;
        prevDx = int'(cand_dx); prevDy = int'(cand_dy); offered = 1;
        if (!abortWithSae && abortAt == nRes) begin
          abort = 1; aborted = 1; timedOut = 0;
          break;
        end
        if (noiseIdx == nRes && !noiseDone) begin
          sae_valid = 1; sae = 1; start = 1; noiseDone = 1;
        end else if (holdIdx == nRes && holdLeft > 0) begin
          holdLeft--;
        end else if (int'($urandom_range(99)) < readyPct) begin
          cand_ready = 1; outstanding = 1; offered = 0;
          curDx = int'(cand_dx); curDy = int'(cand_dy);
          waitLeft = int'($urandom_range(maxDelay));
        end
      end else if (offered) begin
        stabErr++; offered = 0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    nChecks++; if (busy !== 1'b0 || done !== 1'b0 || cand_valid !== 1'b0) begin nFails++;
      $display("FAIL reset_flags: busy=%b done=%b cand_valid=%b expected 0 0 0", busy, done, cand_valid); end
    nChecks++; if (cand_dx !== 0 || cand_dy !== 0 || cand_count !== 0) begin nFails++;
      $display("FAIL reset_cand: dx=%0d dy=%0d count=%0d expected 0 0 0", cand_dx, cand_dy, cand_count); end
    nChecks++; if (best_dx !== 0 || best_dy !== 0 || best_sae !== 0) begin nFails++;
      $display("FAIL reset_best: dx=%0d dy=%0d sae=%0d expected 0 0 0", best_dx, best_dy, best_sae); end
    start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    nChecks++; if (busy !== 1'b1 || cand_valid !== 1'b1) begin nFails++;
      $display("FAIL start_beats_abort: busy=%b cand_valid=%b expected 1 1", busy, cand_valid); end
    abort = 1;
    @(negedge clk);
    abort = 0;
    nChecks++; if (busy !== 1'b0 || cand_valid !== 1'b0 || done !== 1'b0) begin nFails++;
      $display("FAIL abort_in_issue: busy=%b cand_valid=%b done=%b expected 0 0 0", busy, cand_valid, done); end
  endtask

  task automatic test_full_sweep();
    int nRes, oErr, sErr, dCyc, bDx, bDy;
    bit ab, to;
    logic [SAE_W-1:0] bSae;
    model_sweep(0, bDx, bDy, bSae);
    drive_sweep(0, 100, 0, -1, -1, -1, 0, nRes, oErr, sErr, dCyc, ab, to);
    nChecks++; if (to !== 1'b0 || dCyc !== 1923) begin nFails++;
      $display("FAIL full_done_cycle: timeout=%b cycle=%0d expected 0 1923", to, dCyc); end
    nChecks++; if (nRes !== NC || oErr !== 0 || cand_count !== NC) begin nFails++;
      $display("FAIL full_count_order: results=%0d order_err=%0d count=%0d expected %0d 0 %0d", nRes, oErr, cand_count, NC, NC); end
    nChecks++; if (best_dx !== bDx || best_dy !== bDy || best_sae !== bSae) begin nFails++;
      $display("FAIL full_best: got (%0d,%0d) %0d expected (%0d,%0d) %0d", best_dx, best_dy, best_sae, bDx, bDy, bSae); end
    nChecks++; if (busy !== 1'b1 || done !== 1'b1) begin nFails++;
      $display("FAIL full_done_cycle_busy: busy=%b done=%b expected 1 1", busy, done); end
    @(negedge clk);
    nChecks++; if (busy !== 1'b0 || done !== 1'b0) begin nFails++;
      $display("FAIL full_after_done: busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_saturation();
    int nRes, oErr, sErr, dCyc, bDx, bDy;
    bit ab, to;
    logic [SAE_W-1:0] bSae;
    model_sweep(1, bDx, bDy, bSae);
    drive_sweep(1, 100, 0, -1, -1, -1, 0, nRes, oErr, sErr, dCyc, ab, to);
    nChecks++; if (to !== 1'b0 || best_dx !== bDx || best_dy !== bDy || best_sae !== bSae) begin nFails++;
      $display("FAIL saturation_best: timeout=%b got (%0d,%0d) %h expected (%0d,%0d) %h", to, best_dx, best_dy, best_sae, bDx, bDy, bSae); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int nRes, oErr, sErr, dCyc, bDx, bDy, doneSeen;
    bit ab, to;
    logic [SAE_W-1:0] bSae;
    model_sweep(0, bDx, bDy, bSae);
    drive_sweep(0, 100, 0, -1, -1, -1, 0, nRes, oErr, sErr, dCyc, ab, to);
    @(negedge clk);
    fill_random();
    drive_sweep(2, 100, 0, -1, -1, 200, 0, nRes, oErr, sErr, dCyc, ab, to);
    nChecks++; if (ab !== 1'b1 || nRes !== 200) begin nFails++;
      $display("FAIL abort_reached: aborted=%b results=%0d expected 1 200", ab, nRes); end
    @(negedge clk);
    abort = 0;
    nChecks++; if (busy !== 1'b0 || cand_valid !== 1'b0 || done !== 1'b0 || cand_count !== 200) begin nFails++;
      $display("FAIL abort_response: busy=%b valid=%b done=%b count=%0d expected 0 0 0 200", busy, cand_valid, done, cand_count); end
    doneSeen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    nChecks++; if (doneSeen !== 0 || best_dx !== bDx || best_dy !== bDy || best_sae !== bSae) begin nFails++;
      $display("FAIL abort_best_kept: done_seen=%0d got (%0d,%0d) %0d expected 0 (%0d,%0d) %0d", doneSeen, best_dx, best_dy, best_sae, bDx, bDy, bSae); end
    start = 1;
    @(negedge clk);
    start = 0;
    nChecks++; if (cand_valid !== 1'b1 || cand_dx !== -RANGE || cand_dy !== -RANGE || cand_count !== 0) begin nFails++;
      $display("FAIL abort_restart: valid=%b (%0d,%0d) count=%0d expected 1 (%0d,%0d) 0", cand_valid, cand_dx, cand_dy, cand_count, -RANGE, -RANGE); end
    abort = 1;
    @(negedge clk);
    abort = 0;
    drive_sweep(2, 100, 0, -1, -1, 50, 1, nRes, oErr, sErr, dCyc, ab, to);
    @(negedge clk);
    abort = 0; sae_valid = 0;
    nChecks++; if (ab !== 1'b1 || busy !== 1'b0 || cand_count !== 50) begin nFails++;
      $display("FAIL abort_beats_sae: aborted=%b busy=%b count=%0d expected 1 0 50", ab, busy, cand_count); end
    nChecks++; if (best_dx !== bDx || best_dy !== bDy || best_sae !== bSae) begin nFails++;
      $display("FAIL abort_sae_best_kept: got (%0d,%0d) %0d expected (%0d,%0d) %0d", best_dx, best_dy, best_sae, bDx, bDy, bSae); end
  endtask

  task automatic test_backpressure();
    int nRes, oErr, sErr, dCyc, bDx, bDy;
    bit ab, to;
    logic [SAE_W-1:0] bSae;
    fill_random();
    model_sweep(2, bDx, bDy, bSae);
    drive_sweep(2, 100, 0, RANGE * W + RANGE, -1, -1, 0, nRes, oErr, sErr, dCyc, ab, to);
    nChecks++; if (to !== 1'b0 || sErr !== 0 || oErr !== 0) begin nFails++;
      $display("FAIL backpressure_stable: timeout=%b stab_err=%0d order_err=%0d expected 0 0 0", to, sErr, oErr); end
    nChecks++; if (cand_count !== NC || dCyc !== 1926) begin nFails++;
      $display("FAIL backpressure_count: count=%0d cycle=%0d expected %0d 1926", cand_count, dCyc, NC); end
    nChecks++; if (best_dx !== bDx || best_dy !== bDy || best_sae !== bSae) begin nFails++;
      $display("FAIL backpressure_best: got (%0d,%0d) %0d expected (%0d,%0d) %0d", best_dx, best_dy, best_sae, bDx, bDy, bSae); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int nRes, oErr, sErr, dCyc, bDx, bDy;
    bit ab, to;
    logic [SAE_W-1:0] bSae;
    fill_random();
    model_sweep(2, bDx, bDy, bSae);
    drive_sweep(2, 60, 3, -1, -1, -1, 0, nRes, oErr, sErr, dCyc, ab, to);
    nChecks++; if (to !== 1'b0 || sErr !== 0 || oErr !== 0 || cand_count !== NC) begin nFails++;
      $display("FAIL random_flow: timeout=%b stab=%0d order=%0d count=%0d expected 0 0 0 %0d", to, sErr, oErr, cand_count, NC); end
    nChecks++; if (best_dx !== bDx || best_dy !== bDy || best_sae !== bSae) begin nFails++;
      $display("FAIL random_best: got (%0d,%0d) %0d expected (%0d,%0d) %0d", best_dx, best_dy, best_sae, bDx, bDy, bSae); end
    @(negedge clk);
  endtask

  task automatic test_noise();
    int nRes, oErr, sErr, dCyc, bDx, bDy;
    bit ab, to;
    logic [SAE_W-1:0] bSae;
    fill_random();
    model_sweep(2, bDx, bDy, bSae);
    drive_sweep(2, 100, 0, -1, int'($urandom_range(10, 900)), -1, 0, nRes, oErr, sErr, dCyc, ab, to);
    nChecks++; if (to !== 1'b0 || cand_count !== NC || oErr !== 0) begin nFails++;
      $display("FAIL noise_count: timeout=%b count=%0d order=%0d expected 0 %0d 0", to, cand_count, oErr, NC); end
    nChecks++; if (best_dx !== bDx || best_dy !== bDy || best_sae !== bSae) begin nFails++;
      $display("FAIL noise_best: got (%0d,%0d) %0d expected (%0d,%0d) %0d", best_dx, best_dy, best_sae, bDx, bDy, bSae); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    start = 1;
    @(negedge clk);
    start = 0; cand_ready = 1; sae_valid = 1; sae = 5;
    repeat (7) @(negedge clk);
    #2 rst_n = 0;
    #1;
    nChecks++; if (busy !== 1'b0 || done !== 1'b0 || cand_valid !== 1'b0 || cand_count !== 0) begin nFails++;
      $display("FAIL async_reset_ctrl: busy=%b done=%b valid=%b count=%0d expected 0 0 0 0", busy, done, cand_valid, cand_count); end
    nChecks++; if (cand_dx !== 0 || cand_dy !== 0 || best_dx !== 0 || best_dy !== 0 || best_sae !== 0) begin nFails++;
      $display("FAIL async_reset_vec: cand (%0d,%0d) best (%0d,%0d) %0d expected zeros", cand_dx, cand_dy, best_dx, best_dy, best_sae); end
    cand_ready = 0; sae_valid = 0;
    @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    nChecks++; if (cand_valid !== 1'b1 || cand_dx !== -RANGE || cand_dy !== -RANGE || cand_count !== 0) begin nFails++;
      $display("FAIL reset_restart: valid=%b (%0d,%0d) count=%0d expected 1 (%0d,%0d) 0", cand_valid, cand_dx, cand_dy, cand_count, -RANGE, -RANGE); end
    abort = 1;
    @(negedge clk);
    abort = 0;
  endtask

  initial begin
    rst_n = 0; start = 0; abort = 0; cand_ready = 0; sae_valid = 0; sae = '0;
    #23 rst_n = 1;
    @(negedge clk);
    test_reset();
    test_full_sweep();
    test_saturation();
    test_abort();
    test_backpressure();
    test_random();
    test_noise();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
